// File: rtl/gerson_pkg.sv
// rtl/gerson_pkg.sv - shared types and constants for the Gerson sum transmitter
package gerson_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CARRY,
    STOP
  } state_e;

  localparam int LOAD_A = 0;
  localparam int SEND   = 1;
  localparam int TX     = 2;
  localparam int BUSY   = 3;
  localparam int DONE   = 4;

  localparam int         FRAME_BITS  = 11;
  localparam logic [7:0] UIO_OE_MASK = 8'h1C;

  // Full line image, bit 0 goes out first: start, sum[7:0] LSB first, carry, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [8:0] sum);
    return {1'b1, sum[8], sum[7:0], 1'b0};
  endfunction

endpackage

// File: rtl/gerson_if.sv
// rtl/gerson_if.sv - TinyTapeout pin bundle between host and sum transmitter
interface gerson_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with a one-cycle rising-edge pulse
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  // [0],[1] are the synchronizer stages, [2] holds the previous synchronized level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb sync_d = {sync_q[1:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tt_um_gerson_sum_tx.sv
// rtl/tt_um_gerson_sum_tx.sv - latches A, adds B on send, shifts the 9-bit sum out as an 11-bit frame
module tt_um_gerson_sum_tx
  import gerson_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ena,
  gerson_if.slave  io
);

  localparam int               BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic load_pulse;
  logic send_pulse;

  sync_edge u_sync_load (.clk(clk), .rst_n(rst_n), .d(io.uio_in[LOAD_A]), .pulse(load_pulse));
  sync_edge u_sync_send (.clk(clk), .rst_n(rst_n), .d(io.uio_in[SEND]),   .pulse(send_pulse));

  state_e                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;
  logic [7:0]              uo_q, uo_d;
  logic [7:0]              reg_a_q, reg_a_d;
  logic [8:0]              sum;
  logic                    bit_end;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    uo_d      = uo_q;
    // The send below reads reg_a_q, so a simultaneous load only affects the next send.
    reg_a_d   = load_pulse ? io.ui_in : reg_a_q;
    sum       = {1'b0, reg_a_q} + {1'b0, io.ui_in};
    bit_end   = (baud_q == BAUD_LAST);

    if (state_q == IDLE) begin
      tx_d = 1'b1;
      if (send_pulse) begin
        state_d = START;
        baud_d  = '0;
        shift_d = make_frame(sum);
        tx_d    = 1'b0;
        uo_d    = sum[7:0];
      end
    end else begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if (bit_end) begin
        shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
        tx_d    = shift_q[1];
        unique case (state_q)
          START: begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
          DATA: begin
            if (bit_idx_q == 3'd7) state_d = CARRY;
            else                   bit_idx_d = bit_idx_q + 1'b1;
          end
          CARRY: state_d = STOP;
          STOP: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '1;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      uo_q      <= '0;
      reg_a_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      uo_q      <= uo_d;
      reg_a_q   <= reg_a_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ena, io.uio_in[7:2]};

  assign io.uo_out  = uo_q;
  assign io.uio_out = {3'b000, done_q, (state_q != IDLE), tx_q, 2'b00};
  assign io.uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_gerson_sum_tx.sv
// tb/tb_tt_um_gerson_sum_tx.sv - self-checking bench for the Gerson sum transmitter
module tb_tt_um_gerson_sum_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_drv = 8'h00;
  logic [7:0] uio_drv = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  gerson_if io ();
  assign io.ui_in  = ui_drv;
  assign io.uio_in = uio_drv;

  tt_um_gerson_sum_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (1'b1),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a send/load takes effect at the edge where the pin was
  // high two edges earlier and low three edges earlier; a frame then lasts 44 cycles.
  logic [3:0]  m_snd_h, m_ld_h;
  logic [7:0]  m_a, m_uo;
  logic [10:0] m_frame;
  logic [8:0]  m_sum;
  bit          m_busy, m_done;
  int          m_t;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_snd_h = '0; m_ld_h = '0; m_a = '0; m_uo = '0;
      m_frame = '1; m_busy = 0; m_done = 0; m_t = 0;
    end else begin
      m_snd_h = {m_snd_h[2:0], uio_drv[1]};
      m_ld_h  = {m_ld_h[2:0],  uio_drv[0]};
      m_done  = 0;
      if (m_busy) begin
        m_t++;
        if (m_t == 11 * CPB) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (m_snd_h[2] && !m_snd_h[3]) begin
        m_sum   = m_a + ui_drv;
        m_frame = {1'b1, m_sum[8], m_sum[7:0], 1'b0};
        m_busy  = 1;
        m_t     = 0;
        m_uo    = m_sum[7:0];
      end
      if (m_ld_h[2] && !m_ld_h[3]) m_a = ui_drv;
    end
  end

  always @(negedge clk) begin
    check("tx",     {31'd0, io.uio_out[2]}, {31'd0, m_busy ? m_frame[m_t / CPB] : 1'b1});
    check("busy",   {31'd0, io.uio_out[3]}, {31'd0, m_busy});
    check("done",   {31'd0, io.uio_out[4]}, {31'd0, m_done});
    check("uo_out", {24'd0, io.uo_out}, {24'd0, m_uo});
    check("uio_out_spare", {24'd0, io.uio_out & 8'hE3}, 32'd0);
    check("uio_oe", {24'd0, io.uio_oe}, 32'h1C);
  end

  task automatic load(input logic [7:0] a);
    @(negedge clk);
    ui_drv = a;
    uio_drv[0] = 1'b1;
    repeat (4) @(negedge clk);
    uio_drv[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit with_load, input bit mid,
                           input logic [7:0] mid_val,
                           output logic [7:0] data, output logic carry, output int blen);
    int t;
    int j;
    @(negedge clk);
    ui_drv = b;
    uio_drv[1] = 1'b1;
    if (with_load) uio_drv[0] = 1'b1;
    t = 0;
    while (!io.uio_out[3] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("frame_start", {31'd0, io.uio_out[3]}, 32'd1);
    check("latency", t, 3);
    blen = 0; data = '0; carry = 1'b0;
    while (io.uio_out[3] && blen < 100) begin
      if (blen == 4) uio_drv[1:0] = 2'b00;
      if (mid && blen == 10) uio_drv[1] = 1'b1;
      if (mid && blen == 16) uio_drv[1] = 1'b0;
      if (mid && blen == 20) begin ui_drv = mid_val; uio_drv[0] = 1'b1; end
      if (mid && blen == 26) uio_drv[0] = 1'b0;
      if (blen % CPB == 2) begin
        j = blen / CPB;
        if (j == 0) check("start_bit", {31'd0, io.uio_out[2]}, 32'd0);
        if (j >= 1 && j <= 8) data[j-1] = io.uio_out[2];
        if (j == 9) carry = io.uio_out[2];
        if (j == 10) check("stop_bit", {31'd0, io.uio_out[2]}, 32'd1);
      end
      @(negedge clk);
      blen++;
    end
    check("done_pulse", {31'd0, io.uio_out[4]}, 32'd1);
    @(negedge clk);
    check("done_width", {31'd0, io.uio_out[4]}, 32'd0);
  endtask

  task automatic count_busy(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (io.uio_out[3]) n++;
    end
  endtask

  logic [7:0] data;
  logic       carry;
  int         blen;
  int         nb;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx",     {31'd0, io.uio_out[2]}, 32'd1);
    check("rst_busy",   {31'd0, io.uio_out[3]}, 32'd0);
    check("rst_done",   {31'd0, io.uio_out[4]}, 32'd0);
    check("rst_uo_out", {24'd0, io.uo_out}, 32'h00);
    check("rst_uio_oe", {24'd0, io.uio_oe}, 32'h1C);

    // Basic frame with carry: 0xC8 + 0x64 = 0x12C.
    load(8'hC8);
    run_frame(8'h64, 0, 0, 8'h00, data, carry, blen);
    check("basic_data",  {24'd0, data}, 32'h2C);
    check("basic_carry", {31'd0, carry}, 32'd1);
    check("basic_busy_len", blen, 44);
    check("basic_uo_out", {24'd0, io.uo_out}, 32'h2C);

    // No carry: 0x01 + 0x01.
    load(8'h01);
    run_frame(8'h01, 0, 0, 8'h00, data, carry, blen);
    check("nocarry_data",  {24'd0, data}, 32'h02);
    check("nocarry_carry", {31'd0, carry}, 32'd0);
    check("nocarry_uo_out", {24'd0, io.uo_out}, 32'h02);

    // Send and load during a frame: send ignored, load kept for the next send.
    load(8'h05);
    run_frame(8'h03, 0, 1, 8'h40, data, carry, blen);
    check("busy_send_data", {24'd0, data}, 32'h08);
    check("busy_send_len", blen, 44);
    count_busy(60, nb);
    check("no_queued_frame", nb, 0);
    run_frame(8'h03, 0, 0, 8'h00, data, carry, blen);
    check("new_a_data", {24'd0, data}, 32'h43);

    // Simultaneous load and send: the send uses the old A.
    load(8'h10);
    run_frame(8'h20, 1, 0, 8'h00, data, carry, blen);
    check("simul_data", {24'd0, data}, 32'h30);
    run_frame(8'h01, 0, 0, 8'h00, data, carry, blen);
    check("simul_next_data", {24'd0, data}, 32'h21);

    // Reset in the middle of DATA: outputs return to idle without a clock edge.
    load(8'h00);
    @(negedge clk);
    ui_drv = 8'h00;
    uio_drv[1] = 1'b1;
    repeat (12) @(negedge clk);
    check("pre_reset_busy", {31'd0, io.uio_out[3]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx",   {31'd0, io.uio_out[2]}, 32'd1);
    check("async_rst_busy", {31'd0, io.uio_out[3]}, 32'd0);
    @(negedge clk);
    uio_drv[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy(60, nb);
    check("no_resume_after_reset", nb, 0);
    run_frame(8'h7F, 0, 0, 8'h00, data, carry, blen);
    check("post_reset_data", {24'd0, data}, 32'h7F);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
